// File: rtl/demux14_stream.sv
// Registered 1-to-4 stream demultiplexer: each input word is steered by in_sel
// into one of four independent 2-entry FIFOs, each draining through its own handshake.
module demux14_stream #(
    parameter int DW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [1:0]      in_sel,
    output logic [3:0]      out_valid,
    input  logic [3:0]      out_ready,
    output logic [4*DW-1:0] out_data,
    output logic            busy
);

    logic [1:0] ch_cnt [4];

    // Full-channel check uses registered counts only, so a pop never frees a slot in the same cycle.
    assign in_ready = rst_n && (ch_cnt[in_sel] != 2'd2);
    assign busy     = |out_valid;

    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
        logic [DW-1:0] slot0_q, slot1_q;
        logic [DW-1:0] slot0_d, slot1_d;
        logic          wr_ptr_q, wr_ptr_d;
        logic          rd_ptr_q, rd_ptr_d;
        logic [1:0]    cnt_q, cnt_d;
        logic          push, pop;

        assign push = in_valid && in_ready && (in_sel == 2'(gi));
        assign pop  = out_valid[gi] && out_ready[gi];

        always_comb begin
            slot0_d  = slot0_q;
            slot1_d  = slot1_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            if (push) begin
                if (wr_ptr_q) slot1_d = in_data;
                else          slot0_d = in_data;
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (push && !pop)      cnt_d = cnt_q + 2'd1;
            else if (pop && !push) cnt_d = cnt_q - 2'd1;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot0_q  <= '0;
                slot1_q  <= '0;
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
                cnt_q    <= 2'd0;
            end else begin
                slot0_q  <= slot0_d;
                slot1_q  <= slot1_d;
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        assign ch_cnt[gi]                = cnt_q;
        assign out_valid[gi]             = (cnt_q != 2'd0);
        // Head word comes straight from the slot array; stale when the channel is empty.
        assign out_data[gi*DW +: DW]     = rd_ptr_q ? slot1_q : slot0_q;
    end

endmodule

// File: tb/tb_demux14_stream.sv
// Self-checking bench for demux14_stream: per-channel queues model the FIFOs,
// and each scenario task compares DUT outputs against that model or fixed values.
module tb_demux14_stream;
    localparam int DW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [1:0]      in_sel;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [4*DW-1:0] out_data;
    logic            busy;

    int tests_run = 0;
    int failed    = 0;

    logic [DW-1:0] q [4][$];
    logic exp_rdy, obs_rdy;

    demux14_stream #(.DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] model_valid();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = (q[k].size() != 0);
        return v;
    endfunction

    // Applies one cycle of stimulus, records in_ready, and advances the queue model.
    task automatic cycle(input logic v, input logic [1:0] s, input logic [DW-1:0] d, input logic [3:0] r);
        @(negedge clk);
        in_valid = v; in_sel = s; in_data = d; out_ready = r;
        #1;
        exp_rdy = rst_n && (q[s].size() < 2);
        obs_rdy = in_ready;
        @(posedge clk);
        for (int k = 0; k < 4; k++)
            if (r[k] && q[k].size() != 0) void'(q[k].pop_front());
        if (v && exp_rdy) q[s].push_back(d);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd2; in_data = '0; out_ready = 4'h0;
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 4'b0000 || out_data !== '0 || busy !== 1'b0) begin
                failed++;
                $display("FAIL reset_hold: in_ready=%b out_valid=%b out_data=%h busy=%b, required 0/0000/00/0",
                         in_ready, out_valid, out_data, busy);
            end
        end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        end
        $display("[TB] reset: done");
    endtask

    task automatic test_single_route();
        cycle(1'b1, 2'd2, 2'b11, 4'h0);
        tests_run++;
        if (out_valid !== 4'b0100 || out_data[2*DW +: DW] !== 2'b11 || busy !== 1'b1) begin
            failed++;
            $display("FAIL single_push: out_valid=%b ch2=%b busy=%b, required 0100/11/1",
                     out_valid, out_data[2*DW +: DW], busy);
        end
        cycle(1'b0, 2'd0, 2'b00, 4'b0100);
        tests_run++;
        if (out_valid !== 4'b0000 || busy !== 1'b0) begin
            failed++;
            $display("FAIL single_pop: out_valid=%b busy=%b, required 0000/0", out_valid, busy);
        end
        $display("[TB] single_route: done");
    endtask

    task automatic test_fill_stall();
        cycle(1'b1, 2'd0, 2'd1, 4'h0);
        cycle(1'b1, 2'd0, 2'd2, 4'h0);
        @(negedge clk);
        in_valid = 1'b0; in_sel = 2'd0; #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            failed++; $display("FAIL full_ready_ch0: in_ready=%b required 0", in_ready);
        end
        in_sel = 2'd1; #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            failed++; $display("FAIL other_ready_ch1: in_ready=%b required 1", in_ready);
        end
        cycle(1'b1, 2'd0, 2'd3, 4'h0);
        tests_run++;
        if (obs_rdy !== 1'b0 || out_data[DW-1:0] !== 2'd1 || out_valid !== 4'b0001) begin
            failed++;
            $display("FAIL third_rejected: ready=%b head=%0d valid=%b, required 0/1/0001",
                     obs_rdy, out_data[DW-1:0], out_valid);
        end
        // Full channel popping in the same cycle still refuses the incoming word.
        cycle(1'b1, 2'd0, 2'd3, 4'b0001);
        tests_run++;
        if (obs_rdy !== 1'b0 || out_data[DW-1:0] !== 2'd2 || out_valid !== 4'b0001) begin
            failed++;
            $display("FAIL full_pop_no_push: ready=%b head=%0d valid=%b, required 0/2/0001",
                     obs_rdy, out_data[DW-1:0], out_valid);
        end
        cycle(1'b0, 2'd0, 2'd0, 4'b0001);
        tests_run++;
        if (out_valid !== 4'b0000) begin
            failed++; $display("FAIL fill_drain: out_valid=%b required 0000", out_valid);
        end
        $display("[TB] fill_stall: done");
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 2'd3, DW'(i % 4), 4'b1000);
            tests_run++;
            if (obs_rdy !== 1'b1 || out_valid !== 4'b1000 || out_data[3*DW +: DW] !== DW'(i % 4)) begin
                failed++;
                $display("FAIL stream_%0d: ready=%b valid=%b ch3=%0d, required 1/1000/%0d",
                         i, obs_rdy, out_valid, out_data[3*DW +: DW], i % 4);
            end
        end
        cycle(1'b0, 2'd0, 2'd0, 4'b1000);
        tests_run++;
        if (out_valid !== 4'b0000) begin
            failed++; $display("FAIL stream_drain: out_valid=%b required 0000", out_valid);
        end
        $display("[TB] streaming: done");
    endtask

    task automatic test_interleave();
        int accepted_other = 0;
        for (int i = 0; i < 200; i++) begin
            logic [3:0] r;
            logic [1:0] s;
            s = 2'(i % 4);
            r = 4'($urandom_range(0, 15));
            if (i < 100) r[1] = 1'b0;
            cycle(1'($urandom_range(0, 3) != 0), s, DW'($urandom), r);
            tests_run++;
            if (obs_rdy !== exp_rdy) begin
                failed++;
                $display("FAIL rr_ready_%0d: in_ready=%b required %b (sel=%0d)", i, obs_rdy, exp_rdy, s);
            end
            if (i < 100 && s != 2'd1 && in_valid && obs_rdy) accepted_other++;
            tests_run++;
            if (out_valid !== model_valid()) begin
                failed++;
                $display("FAIL rr_valid_%0d: out_valid=%b required %b", i, out_valid, model_valid());
            end
            for (int k = 0; k < 4; k++) begin
                if (q[k].size() != 0) begin
                    tests_run++;
                    if (out_data[k*DW +: DW] !== q[k][0]) begin
                        failed++;
                        $display("FAIL rr_data_%0d_ch%0d: out_data=%0d required %0d",
                                 i, k, out_data[k*DW +: DW], q[k][0]);
                    end
                end
            end
        end
        tests_run++;
        if (accepted_other < 20) begin
            failed++;
            $display("FAIL rr_independence: words accepted for ch0/2/3 while ch1 stalled=%0d required >=20",
                     accepted_other);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 2'd0, 4'hF);
        $display("[TB] interleave: done");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) cycle(1'b1, 2'(i % 4), DW'(i + 1), 4'h0);
        tests_run++;
        if (out_valid !== 4'b1111) begin
            failed++; $display("FAIL mid_fill: out_valid=%b required 1111", out_valid);
        end
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        for (int k = 0; k < 4; k++) q[k].delete();
        tests_run++;
        if (out_valid !== 4'b0000 || busy !== 1'b0 || in_ready !== 1'b0 || out_data !== '0) begin
            failed++;
            $display("FAIL mid_reset_async: valid=%b busy=%b ready=%b data=%h, required 0000/0/0/00",
                     out_valid, busy, in_ready, out_data);
        end
        cycle(1'b1, 2'd1, 2'd3, 4'hF);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 2'(i % 4), 2'd0, 4'hF);
            tests_run++;
            if (out_valid !== 4'b0000) begin
                failed++; $display("FAIL mid_no_stale_%0d: out_valid=%b required 0000", i, out_valid);
            end
        end
        cycle(1'b1, 2'd1, 2'd2, 4'h0);
        tests_run++;
        if (out_valid !== 4'b0010 || out_data[DW +: DW] !== 2'd2) begin
            failed++;
            $display("FAIL mid_resume: valid=%b ch1=%0d required 0010/2", out_valid, out_data[DW +: DW]);
        end
        $display("[TB] reset_mid: done");
    endtask

    initial begin
        test_reset();
        test_single_route();
        test_fill_stall();
        test_streaming();
        test_interleave();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
